seq_alu_unit: RTL and testbench

SEQ_ALU_UNIT -- requirements
Module: seq_alu_unit

---
 rtl/seq_alu_unit.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: sequential ALU, single-cycle logic/arith ops plus iterative MUL.
// Define SEQ_ALU_DIVIDE_EN to add an unsigned restoring divider on FunctC 1011.
module seq_alu_unit #(
    parameter int WIDTH     = 32,
    parameter int FLAGS_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       FunctC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Final,
    output logic             Zero,
    output logic             CarryOut,
    output logic             OverFlow,
    output logic             Illegal
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1010;
`ifdef SEQ_ALU_DIVIDE_EN
    localparam logic [3:0] OP_DIV = 4'b1011;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [HALF-1:0]  mplier;

    logic accept;
    logic is_mul;
    logic is_div;
    logic multi;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_ill;

    // DONE is the result-writing cycle; done rises on the edge that leaves it
    assign busy   = (state != IDLE);
    assign accept = start && (state == IDLE);
    assign is_mul = (FunctC == OP_MUL);
    assign multi  = is_mul || is_div;
    assign Zero   = (Final == '0);

`ifdef SEQ_ALU_DIVIDE_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] dif;
    logic             dge;

    assign is_div = (FunctC == OP_DIV);
    assign shl    = {rem, quo[WIDTH-1]};
    assign dif    = shl[WIDTH-1:0] - opb;
    assign dge    = (shl >= {1'b0, opb});
`else
    assign is_div = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = multi ? RUN : DONE;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} + {1'b0, ~opb} + (WIDTH + 1)'(1);

    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        unique case (op)
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_NOR: res = ~(opa | opb);
            OP_ADD: begin
                res   = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                        (add_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
                res_v = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                        (sub_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SLT: begin
                res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
            end
            OP_MUL: res = acc;
`ifdef SEQ_ALU_DIVIDE_EN
            OP_DIV: begin
                res     = quo;
                res_ill = (opb == '0);
            end
`endif
            default: res_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op       <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
`ifdef SEQ_ALU_DIVIDE_EN
            rem      <= '0;
            quo      <= '0;
`endif
            done     <= 1'b0;
            Final    <= '0;
            CarryOut <= 1'b0;
            OverFlow <= 1'b0;
            Illegal  <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                op     <= FunctC;
                opa    <= A;
                opb    <= B;
                cnt    <= is_div ? CW'(WIDTH) : CW'(HALF);
                acc    <= '0;
                mcand  <= {{(WIDTH-HALF){1'b0}}, A[HALF-1:0]};
                mplier <= B[HALF-1:0];
`ifdef SEQ_ALU_DIVIDE_EN
                rem    <= '0;
                quo    <= A;
`endif
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (op == OP_MUL) begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[HALF-1:1]};
                end
`ifdef SEQ_ALU_DIVIDE_EN
                else begin
                    // divide by zero falls out as all-ones quotient
                    rem <= dge ? dif : shl[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], dge};
                end
`endif
            end
            if (state == DONE) begin
                Final    <= res;
                CarryOut <= res_c;
                OverFlow <= res_v;
                Illegal  <= res_ill;
            end else if ((FLAGS_REG == 0) && done) begin
                CarryOut <= 1'b0;
                OverFlow <= 1'b0;
                Illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: directed self-checking bench for seq_alu_unit (WIDTH=32).
module tb_seq_alu_unit;

    localparam int W = 32;

    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SUB = 4'b0110;
    localparam logic [3:0] F_SLT = 4'b0111;
    localparam logic [3:0] F_NOR = 4'b1100;
    localparam logic [3:0] F_MUL = 4'b1010;
    localparam logic [3:0] F_DIV = 4'b1011;
    localparam logic [3:0] F_BAD = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   FunctC;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Final;
    logic         Zero;
    logic         CarryOut;
    logic         OverFlow;
    logic         Illegal;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcyc;

    seq_alu_unit #(
        .WIDTH(W),
        .FLAGS_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .FunctC(FunctC),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .Final(Final),
        .Zero(Zero),
        .CarryOut(CarryOut),
        .OverFlow(OverFlow),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // start one op, scramble inputs after capture, count edges until done
    task automatic run_op(input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit glitch);
        FunctC = f;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        FunctC = ~f;
        A      = $urandom;
        B      = $urandom;
        lat    = 0;
        bcyc   = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            if (glitch && lat >= 2 && lat <= 6) begin
                start  = 1'b1;
                FunctC = F_AND;
                A      = '0;
                B      = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    // flags vector is {busy, Zero, CarryOut, OverFlow, Illegal}
    task automatic chk_res(input string tag, input logic [W-1:0] exp_f,
                           input logic [4:0] exp_fl, input int exp_lat);
        chk({tag, "_lat"}, W'(lat), W'(exp_lat));
        chk({tag, "_final"}, Final, exp_f);
        chk({tag, "_flags"}, {27'b0, busy, Zero, CarryOut, OverFlow, Illegal},
            {27'b0, exp_fl});
    endtask

    initial begin
        int stray;
        rst_n  = 1'b0;
        start  = 1'b0;
        FunctC = '0;
        A      = '0;
        B      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_final", Final, 32'h0);
        chk("rst_ctl", {26'b0, busy, done, Zero, CarryOut, OverFlow, Illegal},
            32'b001000);
        rst_n = 1'b1;

        run_op(F_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
        chk_res("add_ovf", 32'h80000000, 5'b00010, 1);
        @(posedge clk);
        #1;
        chk("add_pulse_hold", {30'b0, done, OverFlow}, 32'b01);

        run_op(F_SUB, 32'd5, 32'd5, 1'b0);
        chk_res("sub_eq", 32'h0, 5'b01100, 1);
        run_op(F_SLT, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk_res("slt_neg", 32'h1, 5'b00000, 1);
        run_op(F_SLT, 32'h1, 32'hFFFFFFFF, 1'b0);
        chk_res("slt_pos", 32'h0, 5'b01000, 1);
        run_op(F_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
        chk_res("and", 32'h00F000F0, 5'b00000, 1);
        run_op(F_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
        chk_res("or", 32'hFFF0FFF0, 5'b00000, 1);
        run_op(F_NOR, 32'h0, 32'h0, 1'b0);
        chk_res("nor0", 32'hFFFFFFFF, 5'b00000, 1);
        run_op(F_NOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
        chk_res("nor1", 32'h0, 5'b01000, 1);
        run_op(F_ADD, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk_res("add_wrap", 32'h0, 5'b01100, 1);
        run_op(F_SUB, 32'h0, 32'h1, 1'b0);
        chk_res("sub_borrow", 32'hFFFFFFFF, 5'b00000, 1);
        run_op(F_SUB, 32'h80000000, 32'h1, 1'b0);
        chk_res("sub_ovf", 32'h7FFFFFFF, 5'b00110, 1);

        run_op(F_MUL, 32'h0000FFFF, 32'h0000FFFF, 1'b1);
        chk_res("mul_max", 32'hFFFE0001, 5'b00000, 17);
        chk("mul_busy", W'(bcyc), 32'd17);
        run_op(F_MUL, 32'hABCD0003, 32'h12340005, 1'b0);
        chk_res("mul_half", 32'h0000000F, 5'b00000, 17);

`ifdef SEQ_ALU_DIVIDE_EN
        run_op(F_DIV, 32'd100, 32'd7, 1'b0);
        chk_res("div", 32'd14, 5'b00000, 33);
        run_op(F_DIV, 32'd100, 32'd0, 1'b0);
        chk_res("div0", 32'hFFFFFFFF, 5'b00001, 33);
`else
        run_op(F_DIV, 32'd100, 32'd7, 1'b0);
        chk_res("div_off", 32'h0, 5'b01001, 1);
`endif
        run_op(F_BAD, 32'h1234, 32'h5678, 1'b0);
        chk_res("illegal", 32'h0, 5'b01001, 1);

        run_op(F_AND, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0);
        chk_res("b2b_and", 32'h0F000F00, 5'b00000, 1);
        FunctC = F_OR;
        A      = 32'hFF00FF00;
        B      = 32'h0F0F0F0F;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_gap", {30'b0, busy, done}, 32'b10);
        @(posedge clk);
        #1;
        chk("b2b_or_done", {30'b0, busy, done}, 32'b01);
        chk("b2b_or_final", Final, 32'hFF0FFF0F);

        FunctC = F_MUL;
        A      = 32'h0000FFFF;
        B      = 32'h0000FFFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_run_final", Final, 32'h0);
        chk("rst_run_ctl", {26'b0, busy, done, Zero, CarryOut, OverFlow, Illegal},
            32'b001000);
        rst_n = 1'b1;
        run_op(F_AND, 32'h12345678, 32'hFFFF0000, 1'b0);
        chk_res("post_rst_and", 32'h12340000, 5'b00000, 1);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        chk("no_stray_done", W'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
